// File: rtl/freq_gen_pkg.sv
// Shared types and default widths for the frequency sweep sequencer.
package freq_gen_pkg;

    // Sweep direction states. IDLE means no sweep is in progress.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sweep_state_e;

    localparam int DATA_W  = 8;
    localparam int DWELL_W = 16;

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Dwell timer: counts enabled cycles and flags the cycle in which the
// count equals the terminal value. The count then returns to zero.
module sweep_dwell_cnt #(
    parameter int DwellWidth = 16
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DwellWidth-1:0] terminal,
    output logic                  expire
);

    logic [DwellWidth-1:0] r_cnt;

    assign expire = enable && (r_cnt == terminal);

    // Count enabled cycles and wrap back to zero on expiry. Clear takes priority.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DwellWidth'(1);
            end
        end
    end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Sweep sequencer for freq_gen. It steps a tuning word between two endpoints,
// holding each word for dwell+1 cycles. The sweep runs once (one-shot) or
// bounces between the endpoints until aborted (continuous).
//
// Handshake: start is a level sampled only in IDLE; the sweep is accepted on
// the first clock edge where start=1 and abort=0. busy stays high from the
// next cycle until the sweep ends. All outputs are registered.
module freq_sweep_ctrl
    import freq_gen_pkg::*;
#(
    parameter int DataWidth  = DATA_W,
    parameter int DwellWidth = DWELL_W
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  continuous,
    input  logic [DataWidth-1:0]  f_start,
    input  logic [DataWidth-1:0]  f_stop,
    input  logic [DataWidth-1:0]  f_step,
    input  logic [DwellWidth-1:0] dwell,
    output logic [DataWidth-1:0]  freq_sel,
    output logic                  freq_upd,
    output logic                  busy,
    output logic                  done,
    output sweep_state_e          dbg_state
);

    // Registered state and outputs
    sweep_state_e          r_state;
    logic [DataWidth-1:0]  r_freq_sel;
    logic                  r_upd;
    logic                  r_busy;
    logic                  r_done;

    // Configuration latched at start. Endpoints are kept as low/high, so the
    // target is simply r_hi going UP and r_lo going DOWN.
    logic [DataWidth-1:0]  r_lo;
    logic [DataWidth-1:0]  r_hi;
    logic [DataWidth-1:0]  r_step;
    logic [DwellWidth-1:0] r_dwell;
    logic                  r_cont;

    // Next-state signals
    sweep_state_e          w_state_nxt;
    logic [DataWidth-1:0]  w_freq_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_latch;
    logic                  w_cnt_clr;
    logic                  w_expire;
    logic [DataWidth-1:0]  w_target;

    // Step one increment toward target. The sum is one bit wider so that
    // overshoot or underflow is caught and clamped instead of wrapping.
    function automatic logic [DataWidth-1:0] f_advance(
        input logic [DataWidth-1:0] cur,
        input logic [DataWidth-1:0] step,
        input logic [DataWidth-1:0] target,
        input logic                 up
    );
        logic [DataWidth:0] sum;
        logic [DataWidth-1:0] res;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, step};
            res = (sum > {1'b0, target}) ? target : sum[DataWidth-1:0];
        end else begin
            sum = {1'b0, cur} - {1'b0, step};
            res = (sum[DataWidth] || (sum < {1'b0, target})) ? target : sum[DataWidth-1:0];
        end
        return res;
    endfunction

    sweep_dwell_cnt #(
        .DwellWidth (DwellWidth)
    ) u_dwell (
        .clk_in   (clk_in),
        .rst      (rst),
        .clear    (w_cnt_clr),
        .enable   (r_state != IDLE),
        .terminal (r_dwell),
        .expire   (w_expire)
    );

    assign w_target = (r_state == DOWN) ? r_lo : r_hi;

    // Next-state logic: accept sweeps, step on dwell expiry, reverse or finish at the target
    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq_sel;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (start && !abort) begin
                    w_latch     = 1'b1;
                    w_state_nxt = (f_stop >= f_start) ? UP : DOWN;
                    w_freq_nxt  = f_start;
                    w_busy_nxt  = 1'b1;
                end
            end
            UP, DOWN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_cnt_clr   = 1'b1;
                end else if (w_expire) begin
                    if (r_freq_sel == w_target) begin
                        if (!r_cont) begin
                            w_state_nxt = IDLE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_cnt_clr   = 1'b1;
                        end else if (r_lo != r_hi) begin
                            // Reverse and take the first step away in the same advance
                            if (r_state == UP) begin
                                w_state_nxt = DOWN;
                                w_freq_nxt  = f_advance(r_freq_sel, r_step, r_lo, 1'b0);
                            end else begin
                                w_state_nxt = UP;
                                w_freq_nxt  = f_advance(r_freq_sel, r_step, r_hi, 1'b1);
                            end
                        end
                    end else begin
                        w_freq_nxt = f_advance(r_freq_sel, r_step, w_target, r_state == UP);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    // State and output registers. freq_upd flags only a real change of freq_sel.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_freq_sel <= '0;
            r_upd      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_freq_sel <= w_freq_nxt;
            r_upd      <= (w_freq_nxt != r_freq_sel);
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Configuration latch. It is only loaded when a sweep is accepted, so input changes while busy are ignored.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_lo    <= '0;
            r_hi    <= '0;
            r_step  <= DataWidth'(1);
            r_dwell <= '0;
            r_cont  <= 1'b0;
        end else if (w_latch) begin
            r_lo    <= (f_stop >= f_start) ? f_start : f_stop;
            r_hi    <= (f_stop >= f_start) ? f_stop : f_start;
            r_step  <= (f_step == '0) ? DataWidth'(1) : f_step;
            r_dwell <= dwell;
            r_cont  <= continuous;
        end
    end

    assign freq_sel  = r_freq_sel;
    assign freq_upd  = r_upd;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl: directed and random sweeps checked cycle by cycle
// against a word-list model of the sweep.
module tb_freq_sweep_ctrl;
    import freq_gen_pkg::*;

    localparam int DW = 8;
    localparam int WW = 16;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          continuous;
    logic [DW-1:0] f_start;
    logic [DW-1:0] f_stop;
    logic [DW-1:0] f_step;
    logic [WW-1:0] dwell;
    logic [DW-1:0] freq_sel;
    logic          freq_upd;
    logic          busy;
    logic          done;
    sweep_state_e  dbg_state;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] m_last_sel;
    logic [DW-1:0] exp_q[$];

    freq_sweep_ctrl #(.DataWidth(DW), .DwellWidth(WW)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .freq_sel   (freq_sel),
        .freq_upd   (freq_upd),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Input noise while busy: none of it may influence the running sweep
    task automatic rand_inputs();
        start      = 1'($urandom_range(0, 1));
        abort      = 1'b0;
        continuous = 1'($urandom_range(0, 1));
        f_start    = 8'($urandom);
        f_stop     = 8'($urandom);
        f_step     = 8'($urandom);
        dwell      = 16'($urandom_range(0, 5));
    endtask

    // One step from cur toward tgt, clamped at tgt
    function automatic int toward(input int cur, input int tgt, input int stp);
        if (tgt > cur) return (cur + stp > tgt) ? tgt : cur + stp;
        if (tgt < cur) return (cur - stp < tgt) ? tgt : cur - stp;
        return cur;
    endfunction

    // Run a sweep and compare every cycle against the model. One-shot sweeps
    // end with the done pulse; continuous sweeps are aborted after ncyc cycles.
    task automatic run_sweep(input int fs, input int fe, input int st, input int dw,
                             input bit cont, input int ncyc);
        int stp;
        int cur;
        int tgt;
        int other;
        int tmp;
        int n;
        logic [DW-1:0] prev;
        exp_q.delete();
        stp   = (st == 0) ? 1 : st;
        cur   = fs;
        tgt   = fe;
        other = fs;
        if (!cont) begin
            forever begin
                repeat (dw + 1) exp_q.push_back(DW'(cur));
                if (cur == fe) break;
                cur = toward(cur, fe, stp);
            end
        end else begin
            while (exp_q.size() < ncyc) begin
                repeat (dw + 1) exp_q.push_back(DW'(cur));
                if (cur == tgt && fs != fe) begin
                    tmp   = tgt;
                    tgt   = other;
                    other = tmp;
                end
                cur = toward(cur, tgt, stp);
            end
            while (exp_q.size() > ncyc) void'(exp_q.pop_back());
        end

        f_start    = DW'(fs);
        f_stop     = DW'(fe);
        f_step     = DW'(st);
        dwell      = WW'(dw);
        continuous = cont;
        abort      = 1'b0;
        start      = 1'b1;
        tick();
        prev = m_last_sel;
        n    = exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("freq_sel", 32'(freq_sel), 32'(exp_q[i]));
            chk("freq_upd", 32'(freq_upd), 32'(exp_q[i] != prev));
            chk("busy", 32'(busy), 32'd1);
            chk("done_low", 32'(done), 32'd0);
            prev = exp_q[i];
            if (i < n - 1) begin
                rand_inputs();
                tick();
            end
        end
        rand_inputs();
        if (!cont) begin
            tick();
            chk("done_pulse", 32'(done), 32'd1);
            chk("busy_end", 32'(busy), 32'd0);
            chk("sel_end", 32'(freq_sel), 32'(fe));
            chk("upd_end", 32'(freq_upd), 32'd0);
            chk("state_end", 32'(dbg_state), 32'(IDLE));
        end else begin
            abort = 1'b1;
            tick();
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_sel", 32'(freq_sel), 32'(prev));
            chk("abort_upd", 32'(freq_upd), 32'd0);
            chk("abort_state", 32'(dbg_state), 32'(IDLE));
        end
        start      = 1'b0;
        abort      = 1'b0;
        m_last_sel = prev;
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        continuous = 1'b0;
        f_start    = '0;
        f_stop     = '0;
        f_step     = '0;
        dwell      = '0;
        m_last_sel = '0;

        // Reset state
        repeat (2) tick();
        chk("rst_sel", 32'(freq_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_upd", 32'(freq_upd), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b1;
        tick();

        // Asynchronous reset while sweeping up
        f_start = 8'd10; f_stop = 8'd200; f_step = 8'd1; dwell = 16'd0; continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_rst_sel", 32'(freq_sel), 32'd13);
        chk("pre_rst_state", 32'(dbg_state), 32'(UP));
        #2 rst = 1'b0;
        #1;
        chk("async_rst_sel", 32'(freq_sel), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_state", 32'(dbg_state), 32'(IDLE));
        #2 rst = 1'b1;
        tick();
        m_last_sel = '0;

        // Directed sweeps (back-to-back: each starts the cycle after the previous done)
        run_sweep(10, 20, 4, 2, 1'b0, 0);
        run_sweep(250, 3, 100, 0, 1'b0, 0);
        run_sweep(5, 7, 0, 1, 1'b0, 0);
        run_sweep(9, 9, 1, 3, 1'b0, 0);
        run_sweep(0, 255, 128, 0, 1'b1, 14);
        run_sweep(9, 9, 2, 0, 1'b1, 10);

        // start and abort together in IDLE: nothing happens
        f_start = 8'd77; f_stop = 8'd99; f_step = 8'd3; dwell = 16'd0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_state", 32'(dbg_state), 32'(IDLE));
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_sel", 32'(freq_sel), 32'(m_last_sel));
        chk("sa_upd", 32'(freq_upd), 32'd0);
        tick();
        chk("sa_state2", 32'(dbg_state), 32'(IDLE));

        // Random one-shot and continuous sweeps
        for (int k = 0; k < 8; k++) begin
            run_sweep(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), 1'b0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            run_sweep(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 120)), int'($urandom_range(0, 2)), 1'b1,
                      int'($urandom_range(30, 60)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
